// File: rtl/ddco_pkg.sv
// ddco_pkg
// Shared definitions for the lab-circuit sweep blocks: sequencer state
// encoding, number of test vectors, vector width and mismatch counter width.
package ddco_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int NUM_VECTORS = 8;
    localparam int VEC_W       = 3;
    // Holds 0..8 (a full miss on every vector), so it can never overflow.
    localparam int MISM_W      = 4;

    localparam logic [VEC_W-1:0] LAST_IDX = VEC_W'(NUM_VECTORS - 1);

endpackage

// File: rtl/truth_table_sequencer_if.sv
// truth_table_sequencer_if
// Bundles the control, test-vector and result signals of the truth-table
// sequencer.
//   slave  : the sequencer itself (takes start/abort/Z, drives vector+results)
//   master : the controller / circuit-under-test side
// Signals:
//   start, abort           control requests
//   Z                      output of the combinational circuit under test
//   A2, B2, C2             current test vector (A2 = MSB)
//   busy, done, pass       sweep status
//   table_out              captured truth table, bit i = Z at vector i
//   mismatches             number of bits differing from the golden table
interface truth_table_sequencer_if;
    import ddco_pkg::*;

    logic                   start;
    logic                   abort;
    logic                   Z;
    logic                   A2;
    logic                   B2;
    logic                   C2;
    logic                   busy;
    logic                   done;
    logic                   pass;
    logic [NUM_VECTORS-1:0] table_out;
    logic [MISM_W-1:0]      mismatches;

    modport slave (
        input  start, abort, Z,
        output A2, B2, C2, busy, done, pass, table_out, mismatches
    );

    modport master (
        output start, abort, Z,
        input  A2, B2, C2, busy, done, pass, table_out, mismatches
    );

endinterface

// File: rtl/truth_table_sequencer_hold_timer.sv
// hold_timer
// Down-counter that measures a fixed number of cycles. It reloads to
// LOAD_VALUE-1 on load, or automatically when it expires while enabled, so
// with en held high expire pulses once every LOAD_VALUE cycles.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   load       : restart the interval (takes priority over counting)
//   en         : count down one step per cycle
//   expire     : high in the last cycle of the interval (count == 0)
module hold_timer #(
    parameter int LOAD_VALUE = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic expire
);

    localparam int            W      = $clog2(LOAD_VALUE + 1);
    localparam logic [W-1:0]  RELOAD = W'(LOAD_VALUE - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign expire = (cnt_q == '0);

    always_comb begin
        cnt_d = cnt_q;
        if (load || (en && expire)) begin
            cnt_d = RELOAD;
        end else if (en) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= RELOAD;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/truth_table_sequencer.sv
// truth_table_sequencer
// Drives a 3-input combinational circuit through all 8 input combinations in
// binary order, holds each for HOLD_CYCLES cycles, samples Z at the end of
// each hold, and reports the captured table, the mismatch count against
// EXPECTED and a pass flag.
// Parameters:
//   HOLD_CYCLES : cycles each vector is held (1..255)
//   EXPECTED    : golden table, bit i = expected Z for {A2,B2,C2} = i
// Ports:
//   clk, rst_n  : clock and asynchronous active-low reset
//   bus         : slave side of truth_table_sequencer_if
module truth_table_sequencer
    import ddco_pkg::*;
#(
    parameter int                     HOLD_CYCLES = 2,
    parameter logic [NUM_VECTORS-1:0] EXPECTED    = 8'hE8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    truth_table_sequencer_if.slave  bus
);

    state_t                 state_q,  state_d;
    logic [VEC_W-1:0]       idx_q,    idx_d;
    logic [NUM_VECTORS-1:0] cap_q,    cap_d;
    logic [MISM_W-1:0]      mism_q,   mism_d;
    logic [NUM_VECTORS-1:0] table_q,  table_d;
    logic                   pass_q,   pass_d;

    logic hold_expire;
    logic in_apply;

    assign in_apply = (state_q == APPLY);

    // The timer is held at its reload value throughout IDLE so the first
    // vector of a sweep gets a full HOLD_CYCLES interval; while sweeping it
    // reloads itself on every capture.
    hold_timer #(
        .LOAD_VALUE (HOLD_CYCLES)
    ) u_hold_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (state_q == IDLE),
        .en     (in_apply),
        .expire (hold_expire)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cap_d   = cap_q;
        mism_d  = mism_q;
        table_d = table_q;
        pass_d  = pass_q;

        case (state_q)
            IDLE: begin
                // abort wins over a simultaneous start
                if (bus.start && !bus.abort) begin
                    state_d = APPLY;
                    idx_d   = '0;
                    cap_d   = '0;
                    mism_d  = '0;
                end
            end

            APPLY: begin
                // abort beats a capture on the same edge, and leaves the
                // published table_out/pass untouched
                if (bus.abort) begin
                    state_d = IDLE;
                end else if (hold_expire) begin
                    cap_d[idx_q] = bus.Z;
                    if (bus.Z != EXPECTED[idx_q]) begin
                        mism_d = mism_q + 1'b1;
                    end
                    if (idx_q == LAST_IDX) begin
                        // idx is left at 7 so the vector never wraps to 000
                        // while still in APPLY; results publish with DONE
                        state_d = DONE;
                        table_d = cap_d;
                        pass_d  = (cap_d == EXPECTED);
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cap_q   <= '0;
            mism_q  <= '0;
            table_q <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cap_q   <= cap_d;
            mism_q  <= mism_d;
            table_q <= table_d;
            pass_q  <= pass_d;
        end
    end

    // Outputs come straight from flops (vector gated by the APPLY state), so
    // an asserted rst_n clears all of them without waiting for a clock edge.
    assign bus.busy       = in_apply;
    assign bus.done       = (state_q == DONE);
    assign bus.A2         = in_apply & idx_q[2];
    assign bus.B2         = in_apply & idx_q[1];
    assign bus.C2         = in_apply & idx_q[0];
    assign bus.pass       = pass_q;
    assign bus.table_out  = table_q;
    assign bus.mismatches = mism_q;

endmodule

// File: tb/tb_truth_table_sequencer.sv
// tb_truth_table_sequencer
// Two sequencer instances: "a" with HOLD_CYCLES=2 / EXPECTED=8'hE8 and a
// selectable Z model, "b" with HOLD_CYCLES=1 / EXPECTED=8'h00 and Z tied low.
// Expected sweep results (table, pass, mismatches, done cycle) are queued
// when a start is driven and compared when the DUT pulses done.
module tb_truth_table_sequencer;

    typedef struct {
        logic [7:0] tbl;
        logic       pass;
        logic [3:0] mism;
        int         done_cyc;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc = 0;
    int   n_total = 0;
    int   n_bad = 0;
    int   a_mode = 0;   // 0 = majority, 1 = xor, 2 = constant 0

    exp_t qa[$];
    exp_t qb[$];

    truth_table_sequencer_if ifa ();
    truth_table_sequencer_if ifb ();

    truth_table_sequencer #(
        .HOLD_CYCLES (2),
        .EXPECTED    (8'hE8)
    ) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifa)
    );

    truth_table_sequencer #(
        .HOLD_CYCLES (1),
        .EXPECTED    (8'h00)
    ) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifb)
    );

    function automatic logic zmodel(input int mode, input logic [2:0] v);
        case (mode)
            0:       return (v[2] & v[1]) | (v[2] & v[0]) | (v[1] & v[0]);
            1:       return v[2] ^ v[1] ^ v[0];
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [7:0] model_table(input int mode);
        logic [7:0] t;
        for (int i = 0; i < 8; i++) begin
            t[i] = zmodel(mode, 3'(i));
        end
        return t;
    endfunction

    assign ifa.Z = zmodel(a_mode, {ifa.A2, ifa.B2, ifa.C2});
    assign ifb.Z = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ---------------- result monitors ----------------
    always @(negedge clk) begin
        if (rst_n && ifa.done) begin
            if (qa.size() == 0) begin
                chk("a_unexpected_done", 32'(ifa.done), 32'd0);
            end else begin
                exp_t e;
                e = qa.pop_front();
                chk("a_table", 32'(ifa.table_out), 32'(e.tbl));
                chk("a_pass", 32'(ifa.pass), 32'(e.pass));
                chk("a_mism", 32'(ifa.mismatches), 32'(e.mism));
                chk("a_done_cycle", 32'(cyc), 32'(e.done_cyc));
                chk("a_vec_in_done", 32'({ifa.A2, ifa.B2, ifa.C2}), 32'd0);
                $display("a sweep: table=%02h pass=%0b mism=%0d at cycle %0d",
                         ifa.table_out, ifa.pass, ifa.mismatches, cyc);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && ifb.done) begin
            if (qb.size() == 0) begin
                chk("b_unexpected_done", 32'(ifb.done), 32'd0);
            end else begin
                exp_t e;
                e = qb.pop_front();
                chk("b_table", 32'(ifb.table_out), 32'(e.tbl));
                chk("b_pass", 32'(ifb.pass), 32'(e.pass));
                chk("b_mism", 32'(ifb.mismatches), 32'(e.mism));
                chk("b_done_cycle", 32'(cyc), 32'(e.done_cyc));
                $display("b sweep: table=%02h pass=%0b mism=%0d at cycle %0d",
                         ifb.table_out, ifb.pass, ifb.mismatches, cyc);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    // Called at a negedge; returns one negedge later with start released.
    task automatic start_a(input int mode);
        exp_t e;
        a_mode     = mode;
        e.tbl      = model_table(mode);
        e.pass     = (e.tbl == 8'hE8);
        e.mism     = 4'($countones(e.tbl ^ 8'hE8));
        e.done_cyc = cyc + 17;
        qa.push_back(e);
        ifa.start = 1'b1;
        @(negedge clk);
        ifa.start = 1'b0;
    endtask

    task automatic wait_a();
        for (int i = 0; i < 60; i++) begin
            if (qa.size() == 0) break;
            @(negedge clk);
            #1;
        end
        if (qa.size() != 0) begin
            chk("a_done_timeout", 32'(qa.size()), 32'd0);
            qa.delete();
        end
    endtask

    task automatic chk_a_zero(input string tag);
        chk({tag, "_busy"}, 32'(ifa.busy), 32'd0);
        chk({tag, "_done"}, 32'(ifa.done), 32'd0);
        chk({tag, "_pass"}, 32'(ifa.pass), 32'd0);
        chk({tag, "_table"}, 32'(ifa.table_out), 32'd0);
        chk({tag, "_mism"}, 32'(ifa.mismatches), 32'd0);
        chk({tag, "_vec"}, 32'({ifa.A2, ifa.B2, ifa.C2}), 32'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int base;
        ifa.start = 1'b0;
        ifa.abort = 1'b0;
        ifb.start = 1'b0;
        ifb.abort = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_a_zero("reset");
        chk("reset_b_table", 32'(ifb.table_out), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Majority sweep with per-cycle vector checks
        start_a(0);
        for (int k = 1; k <= 16; k++) begin
            chk("maj_vec", 32'({ifa.A2, ifa.B2, ifa.C2}), 32'((k - 1) / 2));
            chk("maj_busy", 32'(ifa.busy), 32'd1);
            if (k < 16) @(negedge clk);
        end
        wait_a();
        @(negedge clk);
        chk("idle_busy", 32'(ifa.busy), 32'd0);
        chk("idle_vec", 32'({ifa.A2, ifa.B2, ifa.C2}), 32'd0);

        // XOR sweep, then majority again so E8 is the stored result
        start_a(1);
        wait_a();
        @(negedge clk);
        start_a(0);
        wait_a();
        @(negedge clk);

        // start and abort together in IDLE: stays idle
        ifa.start = 1'b1;
        ifa.abort = 1'b1;
        @(negedge clk);
        ifa.start = 1'b0;
        ifa.abort = 1'b0;
        chk("start_abort_idle_busy", 32'(ifa.busy), 32'd0);

        // Abort in cycle 6 of a sweep
        ifa.start = 1'b1;
        @(negedge clk);
        ifa.start = 1'b0;
        repeat (5) @(negedge clk);
        chk("abort_busy_before", 32'(ifa.busy), 32'd1);
        ifa.abort = 1'b1;
        @(negedge clk);
        ifa.abort = 1'b0;
        chk("abort_busy", 32'(ifa.busy), 32'd0);
        chk("abort_vec", 32'({ifa.A2, ifa.B2, ifa.C2}), 32'd0);
        chk("abort_table", 32'(ifa.table_out), 32'hE8);
        chk("abort_pass", 32'(ifa.pass), 32'd1);
        repeat (20) @(negedge clk);
        start_a(0);
        wait_a();
        @(negedge clk);

        // Asynchronous reset while vector 101 is applied
        start_a(0);
        for (int i = 0; i < 30; i++) begin
            if ({ifa.A2, ifa.B2, ifa.C2} == 3'b101) break;
            @(negedge clk);
        end
        chk("reach_101", 32'({ifa.A2, ifa.B2, ifa.C2}), 32'd5);
        #2;
        rst_n = 1'b0;
        #1;
        chk_a_zero("async_rst");
        qa.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        start_a(0);
        wait_a();
        @(negedge clk);

        // Instance b: start held high for 40 cycles, HOLD_CYCLES=1
        base = cyc;
        for (int j = 0; j < 4; j++) begin
            exp_t e;
            e.tbl      = model_table(2);
            e.pass     = (e.tbl == 8'h00);
            e.mism     = 4'($countones(e.tbl ^ 8'h00));
            e.done_cyc = base + 10 * j + 9;
            qb.push_back(e);
        end
        ifb.start = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 5) chk("b_busy_mid", 32'(ifb.busy), 32'd1);
        end
        ifb.start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (qb.size() == 0) break;
            @(negedge clk);
            #1;
        end
        if (qb.size() != 0) begin
            chk("b_done_timeout", 32'(qb.size()), 32'd0);
            qb.delete();
        end
        repeat (15) @(negedge clk);
        chk("b_idle_busy", 32'(ifb.busy), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
